input_cache_pf: RTL
===================

# input_cache_pf

Parametrised input-activation cache with per-bank fill tracking, round-robin replacement, next-line prefetch, unaligned depthwise (dwen) reads and hit/miss counters. It sits between the MAC array read port and the AXI burst-read master, serving 4-byte lanes from NBK on-chip lines, each filled by one NTFR-beat 64-bit burst. Storage is inferred RAM split into even and odd 64-bit word halves, so any 4-byte window inside a line reads in one cycle.

## Interface
- NBK, 16: number of lines (banks), power of 2, 2..32
- NTFR, 64: 64-bit beats per line fill, power of 2, 8..128; line bytes LB = NTFR*8, NB = log2(LB)
- AW, 24: byte address width
- CW, 32: performance counter width
- clk  in  1  clock; one clock for the whole block
- xrst  in  1  reset; synchronous, active-high
- civ  in  1  cache invalidate, one-cycle pulse
- pfen  in  1  next-line prefetch enable
- dwen  in  1  1: 4 consecutive bytes from adr; 0: byte adr broadcast to 4 lanes
- re  in  1  read enable, held with adr until accepted
- adr  in  AW  byte address
- dr  out  32  read data, lane 0 = byte adr
- rdy  out  1  registered ready / data-valid
- rreq  out  1  burst request
- rack  in  1  beat strobe; first rack also acknowledges rreq
- radr  out  AW  burst start address, LB-aligned
- rdata  in  64  beat data, byte 0 at [7:0]
- hit_cnt, miss_cnt  out  CW each  accepted-hit / demand-miss counters

## Operation
- Per bank: valid, tag = adr[AW-1:NB], full flag. A fill bank fb has fill pointer wpt (bytes written, 0..LB).
- Word-ready: hit bank is full, or bank==fb and wpt > end byte (dwen: min(off+3, LB-1); else off), off = adr[NB-1:0].
- Accept: re && hit && word-ready. rdy(t+1) = !re(t) || accept(t).
- Lanes: dwen=0 -> {b,b,b,b}, b = byte off. dwen=1 -> bytes off..off+3; bytes past LB-1 return 0x00.
- States: Idle, WaitAck, Fill, Drain.
- Idle, re with no hit: demand miss. Victim = rr pointer; tag/valid written, full cleared, fb = victim, wpt = 0, radr = {tag, NB'0}, rreq = 1, rr += 1, miss_cnt += 1 -> WaitAck.
- Idle, pfen, accepted hit on tag T, T+1 not in any bank, T+1 does not wrap past 2^(AW-NB)-1: prefetch fill of T+1, same as miss but no miss_cnt. Victim = rr, or rr+1 if rr equals the hit bank. Demand miss takes priority over prefetch in the same cycle.
- WaitAck: rack -> write beat 0, wpt = 8, rreq = 0 -> Fill.
- Fill: each rack writes beat wpt/8, wpt += 8. Last beat -> full = 1, Idle. A miss arriving during Fill waits, with rdy low, until Fill completes. A prefetch is never aborted.
- Only one fill outstanding. Hits to other banks are served during a fill.
- civ: all valid cleared, rr = 0. In Idle -> stay Idle. In WaitAck/Fill -> Drain, rreq = 0, remaining beats of the burst counted and discarded, then Idle. Counters cleared.
- hit_cnt += 1 per accepted read. Both counters saturate at all-ones.

## Timing
- Reset values: rdy 0, dr 0, rreq 0, radr 0, hit_cnt 0, miss_cnt 0. All valid bits 0, rr 0, state Idle.
- Read latency is 1. Accept at t -> dr valid and rdy 1 at t+1.
- dr = 0 at t+1 if no accept at t.
- Miss to first data: rreq at t+1. If first rack is at ta, the earliest accept is at ta+1 for off < 8, and dr is valid at ta+2.
- radr is stable from rreq rise until first rack.
- rack on the same cycle as civ is discarded and counted toward Drain.
- xrst overrides civ and any state, including mid-fill.

## Test plan
- Cold miss: re, adr=0x000123, dwen=0 -> rreq with radr=0x000000, miss_cnt=1. After 64 racks of pattern byte = addr[7:0], dr = 0x23232323, hit_cnt=1.
- Unaligned dwen: line at 0x000400 filled, adr=0x000405 -> dr = {08,07,06,05}. adr=0x0005FE -> dr = {00,00,FF,FE}.
- Hit under fill: read the 3rd beat at off 0x10 during a fill while rack stalls after beat 1 -> rdy low until beat 2 written, then data correct. A read to another full bank is served with 1-cycle latency meanwhile.
- Prefetch: pfen=1, hit at 0x000000 -> prefetch radr=0x000200, miss_cnt unchanged. A later read at 0x000200 hits with no rreq.
- Replacement: NBK=16, 17 distinct line misses -> the 17th evicts bank 0. Re-reading line 0 -> miss, miss_cnt=18.
- civ mid-fill at beat 10 -> rreq 0, 54 remaining beats discarded, all reads miss afterward, counters 0. xrst mid-fill -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/input_cache_pf.sv
// input_cache_pf: input-activation line cache between the MAC array read port
// and an AXI burst-read master.
//   clk, xrst          : clock, synchronous active-high reset
//   civ                : invalidate pulse (clears valid bits and counters, drains an open burst)
//   pfen               : next-line prefetch enable
//   re, adr, dwen      : read request (held until accepted), byte address, 4-byte window mode
//   dr, rdy            : read data (lane 0 = byte adr), registered ready/data-valid
//   rreq, radr         : line fill request, line-aligned start address
//   rack, rdata        : per-beat strobe and 64-bit beat data
//   hit_cnt, miss_cnt  : saturating accepted-hit / demand-miss counters
module input_cache_pf #(
  parameter int NBK  = 16,
  parameter int NTFR = 64,
  parameter int AW   = 24,
  parameter int CW   = 32
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          civ,
  input  logic          pfen,
  input  logic          dwen,
  input  logic          re,
  input  logic [AW-1:0] adr,
  output logic [31:0]   dr,
  output logic          rdy,
  output logic          rreq,
  input  logic          rack,
  output logic [AW-1:0] radr,
  input  logic [63:0]   rdata,
  output logic [CW-1:0] hit_cnt,
  output logic [CW-1:0] miss_cnt
);
  localparam int LB    = NTFR * 8;
  localparam int NB    = $clog2(LB);
  localparam int TW    = AW - NB;
  localparam int BKW   = $clog2(NBK);
  localparam int NTB   = $clog2(NTFR);
  localparam int HW    = NTB - 1;
  localparam int DEPTH = NBK * NTFR / 2;
  localparam logic [NB:0] LAST_B = (NB+1)'(LB - 1);
  localparam logic [NB:0] LAST_W = (NB+1)'(LB - 8);
  localparam logic [NB:0] BEAT   = (NB+1)'(8);
  localparam logic [NB:0] THREE  = (NB+1)'(3);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, FILL, DRAIN} state_t;
  state_t state;

  logic [NBK-1:0]         vld, full;
  logic [NBK-1:0][TW-1:0] tags;
  logic [BKW-1:0]         fb, rr, hbank, pf_vict, vict;
  logic [NB:0]            wpt;

  // Even and odd 64-bit words of every line live in separate RAMs so a
  // window straddling two words reads both in the same cycle.
  logic [63:0] mem_e [0:DEPTH-1];
  logic [63:0] mem_o [0:DEPTH-1];
  logic [63:0] even_q, odd_q;
  logic        acc_q, dwen_q;
  logic [NB-1:0] off_q;

  logic [TW-1:0] a_tag, nxt_tag, ftag;
  logic [NB-1:0] off;
  logic [NB:0]   off_x, end_x;
  logic [HW-1:0] w_half, e_idx;
  logic          hit, pf_hit, wrdy, accept, miss, pf_go, we;

  assign a_tag   = adr[AW-1:NB];
  assign nxt_tag = a_tag + 1'b1;
  assign off     = adr[NB-1:0];
  assign off_x   = {1'b0, off};

  always_comb begin
    hit = 1'b0; hbank = '0; pf_hit = 1'b0;
    for (int b = 0; b < NBK; b++) begin
      if (vld[b] && tags[b] == a_tag) begin hit = 1'b1; hbank = BKW'(b); end
      if (vld[b] && tags[b] == nxt_tag) pf_hit = 1'b1;
    end
  end

  // Last byte the read touches, clipped to the line end.
  assign end_x  = !dwen ? off_x : ((off_x + THREE > LAST_B) ? LAST_B : off_x + THREE);
  // The fill writes in order, so bytes below wpt in the fill bank are already stored.
  assign wrdy   = full[hbank] || ((hbank == fb) && (wpt > end_x));
  assign accept = re && hit && wrdy;
  assign miss   = re && !hit && (state == IDLE) && !civ;
  assign pf_go  = (state == IDLE) && pfen && accept && !pf_hit && (a_tag != '1) && !civ;
  // Never let the prefetch evict the line that just hit.
  assign pf_vict = (rr == hbank) ? rr + 1'b1 : rr;
  assign vict    = miss ? rr : pf_vict;
  assign ftag    = miss ? a_tag : nxt_tag;

  // Window start word w0 = off/8; when w0 is odd the second word is the next even one.
  assign w_half = off[NB-1:4];
  assign e_idx  = off[3] ? w_half + 1'b1 : w_half;
  assign we     = rack && !civ && (state == WAIT_ACK || state == FILL);

  always_ff @(posedge clk) begin
    if (we && !wpt[3]) mem_e[{fb, wpt[NB-1:4]}] <= rdata;
    if (we &&  wpt[3]) mem_o[{fb, wpt[NB-1:4]}] <= rdata;
    even_q <= mem_e[{hbank, e_idx}];
    odd_q  <= mem_o[{hbank, w_half}];
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state <= IDLE; vld <= '0; full <= '0; tags <= '0; fb <= '0; rr <= '0; wpt <= '0;
      rreq <= 1'b0; radr <= '0; rdy <= 1'b0; acc_q <= 1'b0; off_q <= '0; dwen_q <= 1'b0;
      hit_cnt <= '0; miss_cnt <= '0;
    end else begin
      rdy    <= !re || accept;
      acc_q  <= accept;
      off_q  <= off;
      dwen_q <= dwen;
      if (civ) begin
        hit_cnt <= '0; miss_cnt <= '0;
        vld <= '0; rr <= '0; rreq <= 1'b0;
      end else begin
        if (accept && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        if (miss && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
      case (state)
        IDLE: if (miss || pf_go) begin
          vld[vict]  <= 1'b1;
          tags[vict] <= ftag;
          full[vict] <= 1'b0;
          fb    <= vict;
          wpt   <= '0;
          radr  <= {ftag, {NB{1'b0}}};
          rreq  <= 1'b1;
          rr    <= vict + 1'b1;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (civ) begin
          // a beat arriving with civ is dropped but still counts toward the burst
          wpt   <= rack ? BEAT : '0;
          state <= DRAIN;
        end else if (rack) begin
          wpt <= BEAT; rreq <= 1'b0; state <= FILL;
        end
        FILL: if (rack) begin
          wpt <= wpt + BEAT;
          if (wpt == LAST_W) begin
            state <= IDLE;
            if (!civ) full[fb] <= 1'b1;
          end else if (civ) state <= DRAIN;
        end else if (civ) state <= DRAIN;
        DRAIN: if (rack) begin
          wpt <= wpt + BEAT;
          if (wpt == LAST_W) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output lane select from the two registered words.
  logic [127:0] win;
  logic [3:0]   bi;
  logic [NB:0]  pos;
  always_comb begin
    win = off_q[3] ? {even_q, odd_q} : {odd_q, even_q};
    dr  = '0;
    bi  = '0;
    pos = '0;
    if (acc_q) begin
      for (int i = 0; i < 4; i++) begin
        bi  = {1'b0, off_q[2:0]} + 4'(i);
        pos = {1'b0, off_q} + (NB+1)'(i);
        if (!dwen_q) dr[i*8 +: 8] = win[off_q[2:0]*8 +: 8];
        else if (pos <= LAST_B) dr[i*8 +: 8] = win[bi*8 +: 8];
      end
    end
  end
endmodule
